// File: rtl/spi_ram_loader_if.sv
// RAM loading port between the SPI loader (master) and system memory (slave).
// One request outstanding at a time; a_rvalid_i completes it.
interface spi_ram_loader_if;
  logic        req_o;
  logic        en_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [3:0]  b_en_o;
  logic        a_rvalid_i;

  modport master (
    output req_o, en_o, addr_o, data_o, b_en_o,
    input  a_rvalid_i
  );

  modport slave (
    input  req_o, en_o, addr_o, data_o, b_en_o,
    output a_rvalid_i
  );
endinterface

// File: rtl/spi_ram_loader.sv
// Generic FIFO: write visible on rd_dat one cycle after the write; no internal protection,
// caller never writes when full nor reads when empty.
module spi_ram_loader_fifo #(
  parameter int unsigned W     = 68,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_sys_i,
  input  logic         rst_sys_i,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         empty,
  output logic         full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_vld) begin
        mem[wp_q] <= wr_dat;
        wp_q      <= wp_q + 1'b1;
      end
      if (rd_rdy) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr_vld) - (AW+1)'(rd_rdy);
    end
  end

  assign rd_dat = mem[rp_q];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(DEPTH));
endmodule

// SPI frame parser packing bytes into 32-bit RAM writes; last data byte to req_o is 2 cycles.
// One write outstanding plus FIFO_DEPTH buffered; a word arriving to a full FIFO is dropped and flagged.
module spi_ram_loader #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [7:0]  WRITE_CMD  = 8'h02,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic             ss_ni,
  input  logic [7:0]       rx_byte_i,
  input  logic             rx_valid_i,
  spi_ram_loader_if.master mem,
  output logic             busy_o,
  output logic             overflow_o,
  output logic             cmd_err_o,
  output logic [CNT_W-1:0] word_count_o
);
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ben;
  } wr_t;

  typedef enum logic [1:0] {S_CMD, S_ADDR, S_DATA, S_DROP} state_t;

  state_t      st_q;
  logic        ss_q;
  logic [1:0]  acnt_q, lane_q;
  logic [23:0] ash_q;
  logic [31:0] addr_q, dat_q;
  logic [3:0]  ben_q;
  wr_t         stg_q, out_q, head;
  logic        stg_vld_q, req_q;
  logic [CNT_W-1:0] cnt_q;
  logic        ovf_q, err_q;

  logic        take, word_done;
  logic [31:0] cur_dat;
  logic [3:0]  cur_ben;
  logic        fifo_empty, fifo_full, issue_fifo, bypass, fifo_wr;

  // A byte strobed in the cycle ss_ni rises still belongs to the closing frame.
  always_comb begin
    take      = rx_valid_i && (!ss_ni || !ss_q);
    word_done = take && (st_q == S_DATA) && (lane_q == 2'd3);
    cur_dat   = dat_q;
    cur_ben   = ben_q;
    if (take && st_q == S_DATA) begin
      cur_dat[{lane_q, 3'b000} +: 8] = rx_byte_i;
      cur_ben[lane_q]                = 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      st_q      <= S_CMD;
      ss_q      <= 1'b1;
      acnt_q    <= '0;
      lane_q    <= '0;
      ash_q     <= '0;
      addr_q    <= '0;
      dat_q     <= '0;
      ben_q     <= '0;
      stg_q     <= '0;
      stg_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ss_q      <= ss_ni;
      stg_vld_q <= 1'b0;
      case (st_q)
        S_CMD: if (take) begin
          if (rx_byte_i == WRITE_CMD) begin
            st_q   <= S_ADDR;
            acnt_q <= '0;
          end else begin
            st_q  <= S_DROP;
            err_q <= 1'b1;
          end
        end
        S_ADDR: if (take) begin
          ash_q  <= {ash_q[15:0], rx_byte_i};
          acnt_q <= acnt_q + 2'd1;
          if (acnt_q == 2'd3) begin
            addr_q <= {ash_q, rx_byte_i[7:2], 2'b00};
            st_q   <= S_DATA;
            lane_q <= '0;
            dat_q  <= '0;
            ben_q  <= '0;
          end
        end
        S_DATA: begin
          if (word_done) begin
            stg_q     <= {addr_q, cur_dat, 4'hF};
            stg_vld_q <= 1'b1;
            addr_q    <= addr_q + 32'd4;
            dat_q     <= '0;
            ben_q     <= '0;
            lane_q    <= '0;
          end else if (take) begin
            dat_q  <= cur_dat;
            ben_q  <= cur_ben;
            lane_q <= lane_q + 2'd1;
          end
        end
        default: ;
      endcase
      if (ss_ni) begin
        st_q <= S_CMD;
        if (st_q == S_DATA && !word_done && cur_ben != 4'h0) begin
          stg_q     <= {addr_q, cur_dat, cur_ben};
          stg_vld_q <= 1'b1;
        end
        dat_q  <= '0;
        ben_q  <= '0;
        lane_q <= '0;
      end
    end
  end

  // The head leaves the FIFO when it is issued, so the FIFO only holds words still waiting.
  always_comb begin
    issue_fifo = !req_q && !fifo_empty;
    bypass     = !req_q && fifo_empty && stg_vld_q;
    fifo_wr    = stg_vld_q && !bypass && (!fifo_full || issue_fifo);
  end

  spi_ram_loader_fifo #(.W($bits(wr_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys_i (clk_sys_i),
    .rst_sys_i (rst_sys_i),
    .wr_vld    (fifo_wr),
    .wr_dat    (stg_q),
    .rd_rdy    (issue_fifo),
    .rd_dat    (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      req_q <= 1'b0;
      out_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (stg_vld_q && fifo_full && !issue_fifo) ovf_q <= 1'b1;
      if (req_q) begin
        if (mem.a_rvalid_i) begin
          req_q <= 1'b0;
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (issue_fifo) begin
        req_q <= 1'b1;
        out_q <= head;
      end else if (bypass) begin
        req_q <= 1'b1;
        out_q <= stg_q;
      end
    end
  end

  assign mem.req_o    = req_q;
  assign mem.en_o     = req_q;
  assign mem.addr_o   = out_q.addr;
  assign mem.data_o   = out_q.data;
  assign mem.b_en_o   = out_q.ben;
  assign busy_o       = !ss_ni || stg_vld_q || !fifo_empty || req_q;
  assign overflow_o   = ovf_q;
  assign cmd_err_o    = err_q;
  assign word_count_o = cnt_q;
endmodule
